tmds_link_sequencer: RTL
========================

TMDS_LINK_SEQUENCER -- requirements
Module: tmds_link_sequencer

Interface
REQ-001 SHALL take parameter LOCK_STABLE, default 64: consecutive locked cycles required before releasing serializer reset (range 2-1023).
REQ-002 SHALL take parameter HDMI_MODE, default 1: 1 inserts preamble and guard band; 0 is plain DVI, with no insertion and ch1/ch2 always sending control token 00 outside video.
REQ-003 i_clk  in  1  pixel clock; the single clock, with all logic on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active low.
REQ-005 i_pll_lock  in  1  PLL lock, synchronous to i_clk.
REQ-006 i_de, i_hsync, i_vsync  in  1 each  video timing.
REQ-007 i_tmds_ch0, i_tmds_ch1, i_tmds_ch2  in  10 each  pre-encoded 8b/10b video words, valid when i_de=1.
REQ-008 o_rst_oserdes  out  1  active-high reset to the three 10:1 serializers.
REQ-009 o_data_ch0, o_data_ch1, o_data_ch2  out  10 each  parallel words to the serializers.
REQ-010 o_link_up  out  1  link streaming.
REQ-011 o_err  out  1  sticky flag for a short blanking gap.

Function
REQ-012 SHALL implement the FSM states WAIT_LOCK, WAIT_VSYNC and LINK_UP.
REQ-013 WAIT_LOCK: o_rst_oserdes=1; a counter increments while i_pll_lock=1 and clears to 0 when it is 0.
  - Count reaching LOCK_STABLE -> WAIT_VSYNC, with o_rst_oserdes=0 on the next cycle.
REQ-014 WAIT_VSYNC: all three channels send control token 00 (1101010100); i_vsync rising edge -> LINK_UP, with o_link_up=1 on the next cycle.
REQ-015 In any state, i_pll_lock=0 -> WAIT_LOCK next cycle.
  - o_rst_oserdes=1, o_link_up=0 and the counter cleared that same next cycle.
REQ-016 SHALL delay i_de/i_hsync/i_vsync/i_tmds_ch* through a 10-stage pipeline (PREAMBLE 8 + GUARD 2) and register outputs.
  - Latency from input to o_data_ch* is exactly 11 cycles.
REQ-017 Control tokens {c1,c0}: 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
REQ-018 Control mapping: ch0 carries {vsync,hsync}; ch1 carries {CTL1,CTL0}; ch2 carries {CTL3,CTL2}; CTL bits are 0 except during preamble.
REQ-019 In LINK_UP with delayed DE=1, output the delayed i_tmds_ch* words unchanged.
REQ-020 In LINK_UP, HDMI_MODE=1, an i_de rising edge at cycle t SHALL schedule the following, provided i_de was low for the 10 preceding cycles:
  - output slots t+1..t+8: preamble, CTL0=1, CTL1..3=0, so ch1=0010101011 and ch2=1101010100; ch0 keeps its sync token;
  - output slots t+9..t+10: guard band, ch0=1011001100, ch1=0100110011, ch2=1011001100;
  - slot t+11: first video word.
REQ-021 An i_de rise after fewer than 10 low cycles SHALL:
  - insert no preamble or guard;
  - pass control tokens until video;
  - set o_err=1 (sticky until reset).
REQ-022 A preamble or guard already scheduled SHALL be cancelled if lock is lost.
REQ-023 The delay pipeline SHALL keep running in all states, so that no stale data appears at LINK_UP entry.

Reset
REQ-024 While i_rst_n=0:
  - o_rst_oserdes=1, o_link_up=0, o_err=0;
  - o_data_ch0/1/2=1101010100;
  - FSM=WAIT_LOCK, counters=0, pipeline cleared to DE/sync=0.
REQ-025 Reset assertion SHALL act immediately (asynchronously), and deassertion SHALL take effect on the next i_clk edge.

Verification
REQ-026 Reset, then i_pll_lock=1 held -> o_rst_oserdes falls exactly LOCK_STABLE(64) cycles after lock; a lock glitch at cycle 30 restarts the count.
REQ-027 First i_vsync rise after reset release -> o_link_up=1 next cycle; before it, all channels = 1101010100.
REQ-028 HDMI_MODE=1, 20 blank cycles then DE high for 4 cycles with ch0 word 0x155 ->
  - 8 cycles ch1=0010101011;
  - 2 cycles guard 1011001100/0100110011/1011001100;
  - 0x155 on ch0 exactly 11 cycles after i_de rose.
REQ-029 Blanking gap of 5 cycles -> no preamble or guard, video passes at latency 11, o_err=1 and stays set.
REQ-030 i_pll_lock dropped mid-preamble -> next cycle o_rst_oserdes=1, o_link_up=0, and the preamble is aborted.
REQ-031 HDMI_MODE=0 with the same stimulus as REQ-028 -> no preamble or guard, and ch1/ch2 show 1101010100 whenever DE=0.

Source files
------------

// File: rtl/tmds_link_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmds_link_sequencer
//
// Brings up a TMDS (DVI/HDMI) transmitter link and formats the three parallel
// 10-bit channel words that feed the 10:1 serializers.
//
//   * Holds the serializers in reset until the PLL has been locked for
//     LOCK_STABLE consecutive cycles.
//   * Sends control token 00 on all channels until the first vsync rising
//     edge, then declares the link up.
//   * Delays video timing and pre-encoded words through a 10-stage pipeline.
//     In HDMI mode this gives room to insert an 8-cycle preamble and a
//     2-cycle guard band ahead of every video period. That period must follow
//     at least 10 blanking cycles. A shorter gap gets no insertion and sets
//     a sticky error flag.
//   * Any loss of PLL lock drops straight back to the lock wait. Any
//     insertion in progress is abandoned.
//
// Ports
//   i_clk          pixel clock, all logic on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_pll_lock     PLL lock (synchronous to i_clk)
//   i_de/i_hsync/i_vsync            video timing
//   i_tmds_ch0/1/2 [9:0]            pre-encoded video words (valid when i_de)
//   o_rst_oserdes                   active-high serializer reset
//   o_data_ch0/1/2 [9:0]            registered words to the serializers
//   o_link_up                       link streaming
//   o_err                           sticky short-blanking-gap flag
// -----------------------------------------------------------------------------
module tmds_link_sequencer #(
    parameter int unsigned LOCK_STABLE = 64,
    parameter int unsigned HDMI_MODE   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_lock,
    input  logic       i_de,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [9:0] i_tmds_ch0,
    input  logic [9:0] i_tmds_ch1,
    input  logic [9:0] i_tmds_ch2,
    output logic       o_rst_oserdes,
    output logic [9:0] o_data_ch0,
    output logic [9:0] o_data_ch1,
    output logic [9:0] o_data_ch2,
    output logic       o_link_up,
    output logic       o_err
);

    localparam int unsigned PIPE_DEPTH   = 10;
    localparam logic [3:0]  PREAMBLE_END = 4'd8;   // last preamble slot
    localparam logic [3:0]  GUARD_END    = 4'd10;  // last guard-band slot
    localparam logic [9:0]  LOCK_TARGET  = 10'(LOCK_STABLE);
    localparam bit          HDMI_EN      = (HDMI_MODE != 0);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;
    localparam logic [9:0] GUARD_02 = 10'b1011001100;  // ch0 and ch2
    localparam logic [9:0] GUARD_1  = 10'b0100110011;  // ch1

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        WAIT_VSYNC = 2'd1,
        LINK_UP    = 2'd2
    } state_t;

    // Maps a {c1,c0} control pair onto its TMDS control token.
    function automatic logic [9:0] ctrl_token(input logic [1:0] ctl);
        logic [9:0] tok;
        case (ctl)
            2'b00:   tok = TOKEN_00;
            2'b01:   tok = TOKEN_01;
            2'b10:   tok = TOKEN_10;
            2'b11:   tok = TOKEN_11;
            default: tok = TOKEN_00;
        endcase
        return tok;
    endfunction

    state_t                     state_q, state_d;
    logic [9:0]                 lock_cnt_q, lock_cnt_d;
    logic                       rst_oserdes_q, rst_oserdes_d;
    logic                       link_up_q, link_up_d;
    logic                       err_q, err_d;
    logic [3:0]                 ins_q, ins_d;
    logic [9:0]                 data0_q, data0_d;
    logic [9:0]                 data1_q, data1_d;
    logic [9:0]                 data2_q, data2_d;

    logic [PIPE_DEPTH-1:0]      de_pipe_q;
    logic [PIPE_DEPTH-1:0]      hs_pipe_q;
    logic [PIPE_DEPTH-1:0]      vs_pipe_q;
    logic [PIPE_DEPTH-1:0][9:0] ch0_pipe_q;
    logic [PIPE_DEPTH-1:0][9:0] ch1_pipe_q;
    logic [PIPE_DEPTH-1:0][9:0] ch2_pipe_q;

    logic       streaming_s;
    logic       de_rise_s;
    logic       gap_ok_s;
    logic       start_s;
    logic [3:0] slot_s;
    logic       de_dly_s;
    logic [1:0] sync_dly_s;

    // Delay pipeline: runs in every state so it never holds stale data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_pipe_q  <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            ch0_pipe_q <= '0;
            ch1_pipe_q <= '0;
            ch2_pipe_q <= '0;
        end else begin
            de_pipe_q  <= {de_pipe_q[PIPE_DEPTH-2:0], i_de};
            hs_pipe_q  <= {hs_pipe_q[PIPE_DEPTH-2:0], i_hsync};
            vs_pipe_q  <= {vs_pipe_q[PIPE_DEPTH-2:0], i_vsync};
            ch0_pipe_q <= {ch0_pipe_q[PIPE_DEPTH-2:0], i_tmds_ch0};
            ch1_pipe_q <= {ch1_pipe_q[PIPE_DEPTH-2:0], i_tmds_ch1};
            ch2_pipe_q <= {ch2_pipe_q[PIPE_DEPTH-2:0], i_tmds_ch2};
        end
    end

    // Stage 0 holds the previous cycle's input, so the whole pipeline covers
    // exactly the 10 cycles preceding the current input.
    assign de_rise_s   = i_de & ~de_pipe_q[0];
    assign gap_ok_s    = ~(|de_pipe_q);
    assign streaming_s = (state_q == LINK_UP) & i_pll_lock;
    assign start_s     = HDMI_EN & streaming_s & de_rise_s & gap_ok_s;
    assign de_dly_s    = de_pipe_q[PIPE_DEPTH-1];
    assign sync_dly_s  = {vs_pipe_q[PIPE_DEPTH-1], hs_pipe_q[PIPE_DEPTH-1]};

    // Insertion slot being emitted this cycle (1..10); 0 means none.
    // ins_q remembers the last slot emitted so the sequence continues.
    always_comb begin
        slot_s = 4'd0;
        ins_d  = 4'd0;
        if (!streaming_s) begin
            slot_s = 4'd0;
        end else if (start_s) begin
            slot_s = 4'd1;
        end else if (ins_q != 4'd0) begin
            slot_s = ins_q + 4'd1;
        end else begin
            slot_s = 4'd0;
        end
        if ((slot_s != 4'd0) && (slot_s < GUARD_END)) begin
            ins_d = slot_s;
        end else begin
            ins_d = 4'd0;
        end
    end

    // Link FSM next state, lock counter and the registered status outputs.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!i_pll_lock) begin
                    lock_cnt_d = 10'd0;
                end else if ((lock_cnt_q + 10'd1) == LOCK_TARGET) begin
                    lock_cnt_d = 10'd0;
                    state_d    = WAIT_VSYNC;
                end else begin
                    lock_cnt_d = lock_cnt_q + 10'd1;
                end
            end
            WAIT_VSYNC: begin
                lock_cnt_d = 10'd0;
                if (!i_pll_lock) begin
                    state_d = WAIT_LOCK;
                end else if (i_vsync && !vs_pipe_q[0]) begin
                    state_d = LINK_UP;
                end else begin
                    state_d = WAIT_VSYNC;
                end
            end
            LINK_UP: begin
                lock_cnt_d = 10'd0;
                if (!i_pll_lock) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = LINK_UP;
                end
            end
            default: begin
                lock_cnt_d = 10'd0;
                state_d    = WAIT_LOCK;
            end
        endcase
        rst_oserdes_d = (state_d == WAIT_LOCK);
        link_up_d     = (state_d == LINK_UP);
        // A rise that follows too short a gap cannot carry a preamble.
        err_d = err_q | (HDMI_EN & streaming_s & de_rise_s & ~gap_ok_s);
    end

    // Channel word selection: insertion, delayed video, or control tokens.
    always_comb begin
        data0_d = TOKEN_00;
        data1_d = TOKEN_00;
        data2_d = TOKEN_00;
        if (!streaming_s) begin
            data0_d = TOKEN_00;
            data1_d = TOKEN_00;
            data2_d = TOKEN_00;
        end else if (slot_s != 4'd0) begin
            if (slot_s <= PREAMBLE_END) begin
                // Preamble: CTL0=1 only; ch0 keeps carrying sync.
                data0_d = ctrl_token(sync_dly_s);
                data1_d = ctrl_token(2'b01);
                data2_d = ctrl_token(2'b00);
            end else begin
                data0_d = GUARD_02;
                data1_d = GUARD_1;
                data2_d = GUARD_02;
            end
        end else if (de_dly_s) begin
            data0_d = ch0_pipe_q[PIPE_DEPTH-1];
            data1_d = ch1_pipe_q[PIPE_DEPTH-1];
            data2_d = ch2_pipe_q[PIPE_DEPTH-1];
        end else begin
            data0_d = ctrl_token(sync_dly_s);
            data1_d = ctrl_token(2'b00);
            data2_d = ctrl_token(2'b00);
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= WAIT_LOCK;
            lock_cnt_q    <= 10'd0;
            rst_oserdes_q <= 1'b1;
            link_up_q     <= 1'b0;
            err_q         <= 1'b0;
            ins_q         <= 4'd0;
            data0_q       <= TOKEN_00;
            data1_q       <= TOKEN_00;
            data2_q       <= TOKEN_00;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            rst_oserdes_q <= rst_oserdes_d;
            link_up_q     <= link_up_d;
            err_q         <= err_d;
            ins_q         <= ins_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
        end
    end

    assign o_rst_oserdes = rst_oserdes_q;
    assign o_link_up     = link_up_q;
    assign o_err         = err_q;
    assign o_data_ch0    = data0_q;
    assign o_data_ch1    = data1_q;
    assign o_data_ch2    = data2_q;

endmodule
